// File: rtl/tick_pacer_pkg.sv
// Shared types and default sizing for the tick pacer and its edge detector.
package tick_pacer_pkg;

    localparam int DEFAULT_PULSE_WIDTH = 2;
    localparam int DEFAULT_MIN_GAP     = 4;
    localparam int DEFAULT_COUNT_WIDTH = 4;
    localparam int PHASE_WIDTH         = 4;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } pacerState_t;

    typedef logic [PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector: one-cycle rise pulse when in goes high after being low.
module tick_edge_detect (
    input  logic clock,
    input  logic resetN,
    input  logic in,
    output logic rise
);

    logic prevIn;

    // NOTE: prevIn clears in reset, so a level already high at release reads as a fresh edge.
    always_ff @(posedge clock) begin
        if (!resetN) prevIn <= 1'b0;
        else         prevIn <= in;
    end

    assign rise = in & ~prevIn;

endmodule

// File: rtl/tick_pacer.sv
// Paces bursty tick requests into fixed-width pulses with a minimum low gap.
// Define SRT_TICK_PACER_STATS_EN to add the 16-bit emitCount output.
module tick_pacer
    import tick_pacer_pkg::*;
#(
    parameter int PULSE_WIDTH = DEFAULT_PULSE_WIDTH,
    parameter int MIN_GAP     = DEFAULT_MIN_GAP,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   inTick,
    input  logic                   clearOverflow,
    output logic                   outTick,
    output logic [COUNT_WIDTH-1:0] pending,
    output logic                   busy,
`ifdef SRT_TICK_PACER_STATS_EN
    output logic [15:0]            emitCount,
`endif
    output logic                   overflow
);

    localparam logic [COUNT_WIDTH-1:0] PENDING_MAX = '1;
    localparam phase_t HIGH_RELOAD = phase_t'(PULSE_WIDTH - 1);
    localparam phase_t GAP_RELOAD  = phase_t'(MIN_GAP - 1);

    pacerState_t state;
    phase_t      phase;
    logic        request;
    logic        hasPending;
    logic        phaseDone;
    logic        startPulse;
    logic        dropRequest;

    tick_edge_detect edgeDetect (
        .clock  (clock),
        .resetN (resetN),
        .in     (inTick),
        .rise   (request)
    );

    assign hasPending  = (pending != '0);
    assign phaseDone   = (phase == '0);
    assign startPulse  = hasPending && ((state == IDLE) || ((state == GAP) && phaseDone));
    // A request landing on a launch cycle takes the freed slot, so it is never dropped.
    assign dropRequest = request && !startPulse && (pending == PENDING_MAX);
    assign busy        = (state != IDLE) || hasPending;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state    <= IDLE;
            phase    <= '0;
            outTick  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
`ifdef SRT_TICK_PACER_STATS_EN
            emitCount <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (startPulse) begin
                        state   <= HIGH;
                        phase   <= HIGH_RELOAD;
                        outTick <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phaseDone) begin
                        state   <= GAP;
                        phase   <= GAP_RELOAD;
                        outTick <= 1'b0;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                GAP: begin
                    if (!phaseDone) begin
                        phase <= phase - 1'b1;
                    end else if (startPulse) begin
                        state   <= HIGH;
                        phase   <= HIGH_RELOAD;
                        outTick <= 1'b1;
                    end else begin
                        state <= IDLE;
                        phase <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    phase   <= '0;
                    outTick <= 1'b0;
                end
            endcase

            if (request && !startPulse && !dropRequest) pending <= pending + 1'b1;
            else if (!request && startPulse)             pending <= pending - 1'b1;

            // A fresh drop outranks a simultaneous clear.
            if (dropRequest)        overflow <= 1'b1;
            else if (clearOverflow) overflow <= 1'b0;

`ifdef SRT_TICK_PACER_STATS_EN
            if (startPulse) emitCount <= emitCount + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_tick_pacer.sv
// Bench for tick_pacer: timing-based reference model plus directed scenarios.
module tb_tick_pacer;

    localparam int PW   = 2;
    localparam int GAPW = 4;
    localparam int CW   = 4;
    localparam int PMAX = 15;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          inTick = 1'b0;
    logic          clearOverflow = 1'b0;
    logic          outTick;
    logic [CW-1:0] pending;
    logic          busy;
    logic          overflow;
`ifdef SRT_TICK_PACER_STATS_EN
    logic [15:0]   emitCount;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Model: cycle index, queued requests, and the pulse schedule as absolute times.
    longint cyc        = 0;
    int     mPending   = 0;
    bit     mOverflow  = 1'b0;
    bit     mPrev      = 1'b0;
    longint mLastStart = -100;
    longint mReadyAt   = 0;
    int     mEmit      = 0;

    always #5 clock = ~clock;

    tick_pacer #(
        .PULSE_WIDTH (PW),
        .MIN_GAP     (GAPW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .inTick        (inTick),
        .clearOverflow (clearOverflow),
        .outTick       (outTick),
        .pending       (pending),
        .busy          (busy),
`ifdef SRT_TICK_PACER_STATS_EN
        .emitCount     (emitCount),
`endif
        .overflow      (overflow)
    );

    function automatic bit expOut();
        return (cyc >= mLastStart) && (cyc < mLastStart + PW);
    endfunction

    function automatic bit expBusy();
        return (cyc < mReadyAt) || (mPending != 0);
    endfunction

    // A pulse may launch once the previous pulse plus its gap has elapsed.
    task automatic modelStep();
        bit rise, start, drop;
        if (!resetN) begin
            mPending   = 0;
            mOverflow  = 1'b0;
            mPrev      = 1'b0;
            mLastStart = -100;
            mReadyAt   = cyc + 1;
            mEmit      = 0;
        end else begin
            rise  = inTick && !mPrev;
            start = (mPending > 0) && (cyc + 1 >= mReadyAt);
            drop  = rise && !start && (mPending == PMAX);
            mPending = mPending + ((rise && !drop) ? 1 : 0) - (start ? 1 : 0);
            if (drop)               mOverflow = 1'b1;
            else if (clearOverflow) mOverflow = 1'b0;
            if (start) begin
                mLastStart = cyc + 1;
                mReadyAt   = cyc + 1 + PW + GAPW;
                mEmit      = (mEmit + 1) % 65536;
            end
            mPrev = inTick;
        end
        cyc++;
    endtask

    task automatic compareAll();
        compared++;
        if (outTick !== expOut()) begin
            mismatched++;
            $display("FAIL outTick cycle %0d: got %b want %b", cyc, outTick, expOut());
        end
        compared++;
        if (pending !== mPending[CW-1:0]) begin
            mismatched++;
            $display("FAIL pending cycle %0d: got %0d want %0d", cyc, pending, mPending);
        end
        compared++;
        if (busy !== expBusy()) begin
            mismatched++;
            $display("FAIL busy cycle %0d: got %b want %b", cyc, busy, expBusy());
        end
        compared++;
        if (overflow !== mOverflow) begin
            mismatched++;
            $display("FAIL overflow cycle %0d: got %b want %b", cyc, overflow, mOverflow);
        end
`ifdef SRT_TICK_PACER_STATS_EN
        compared++;
        if (emitCount !== mEmit[15:0]) begin
            mismatched++;
            $display("FAIL emitCount cycle %0d: got %0d want %0d", cyc, emitCount, mEmit);
        end
`endif
    endtask

    // Inputs for the current cycle are already set; advance one edge and observe.
    task automatic cycle();
        @(posedge clock);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic waitIdle();
        int n = 0;
        inTick = 1'b0;
        clearOverflow = 1'b0;
        while ((expBusy() || mPrev) && n < 300) begin
            cycle();
            n++;
        end
        compared++;
        if (n >= 300) begin
            mismatched++;
            $display("FAIL waitIdle: got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        cycle();
        cycle();
        compared += 4;
        if (outTick !== 1'b0)  begin mismatched++; $display("FAIL reset_outTick: got %b want 0", outTick); end
        if (pending !== 4'd0)  begin mismatched++; $display("FAIL reset_pending: got %0d want 0", pending); end
        if (busy !== 1'b0)     begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        resetN = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        waitIdle();
        inTick = 1'b1;
        cycle();
        compared += 2;
        if (pending !== 4'd1) begin mismatched++; $display("FAIL single_pending_n1: got %0d want 1", pending); end
        if (outTick !== 1'b0) begin mismatched++; $display("FAIL single_out_n1: got %b want 0", outTick); end
        inTick = 1'b0;
        cycle();
        compared += 2;
        if (pending !== 4'd0) begin mismatched++; $display("FAIL single_pending_n2: got %0d want 0", pending); end
        if (outTick !== 1'b1) begin mismatched++; $display("FAIL single_out_n2: got %b want 1", outTick); end
        cycle();
        compared++;
        if (outTick !== 1'b1) begin mismatched++; $display("FAIL single_out_n3: got %b want 1", outTick); end
        cycle();
        compared++;
        if (outTick !== 1'b0) begin mismatched++; $display("FAIL single_out_n4: got %b want 0", outTick); end
    endtask

    task automatic test_burst();
        bit eo, eb;
        waitIdle();
        for (int r = 0; r < 24; r++) begin
            inTick = (r == 0) || (r == 2) || (r == 4);
            cycle();
            eo = ((r + 1) inside {[2:3], [8:9], [14:15]});
            eb = (r + 1) < 20;
            compared += 2;
            if (outTick !== eo) begin
                mismatched++;
                $display("FAIL burst_out rel %0d: got %b want %b", r + 1, outTick, eo);
            end
            if (busy !== eb) begin
                mismatched++;
                $display("FAIL burst_busy rel %0d: got %b want %b", r + 1, busy, eb);
            end
        end
    endtask

    task automatic test_saturation();
        bit done = 1'b0;
        waitIdle();
        for (int e = 0; e < 40; e++) begin
            inTick = 1'b1;
            cycle();
            inTick = 1'b0;
            cycle();
        end
        compared++;
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL sat_overflow: got %b want 1", overflow); end
        // Drop together with clear: overflow must remain set.
        for (int n = 0; n < 40 && !done; n++) begin
            if (mPending == PMAX && !mPrev && !(cyc + 1 >= mReadyAt)) begin
                inTick = 1'b1;
                clearOverflow = 1'b1;
                cycle();
                compared += 2;
                if (overflow !== 1'b1) begin mismatched++; $display("FAIL sat_set_wins: got %b want 1", overflow); end
                if (pending !== 4'd15) begin mismatched++; $display("FAIL sat_pending: got %0d want 15", pending); end
                done = 1'b1;
            end else begin
                inTick = !mPrev;
                clearOverflow = 1'b0;
                cycle();
            end
        end
        compared++;
        if (!done) begin mismatched++; $display("FAIL sat_window: got no drop window want one"); end
        inTick = 1'b0;
        clearOverflow = 1'b1;
        cycle();
        compared++;
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL sat_clear: got %b want 0", overflow); end
        clearOverflow = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit done = 1'b0;
        for (int n = 0; n < 150 && !done; n++) begin
            if (mReadyAt == cyc + 1 && mPending == PMAX && !mPrev && !mOverflow) begin
                inTick = 1'b1;
                clearOverflow = 1'b0;
                cycle();
                compared += 3;
                if (pending !== 4'd15) begin mismatched++; $display("FAIL simul_pending: got %0d want 15", pending); end
                if (overflow !== 1'b0) begin mismatched++; $display("FAIL simul_overflow: got %b want 0", overflow); end
                if (outTick !== 1'b1)  begin mismatched++; $display("FAIL simul_out: got %b want 1", outTick); end
                done = 1'b1;
            end else if (mReadyAt == cyc + 2) begin
                inTick = 1'b0;
                clearOverflow = 1'b1;
                cycle();
            end else begin
                inTick = !mPrev;
                clearOverflow = 1'b0;
                cycle();
            end
        end
        compared++;
        if (!done) begin mismatched++; $display("FAIL simul_window: got no aligned exit want one"); end
        waitIdle();
    endtask

    task automatic test_reset_mid();
        int highCycles = 0;
        int rises = 0;
        bit prevOut = 1'b0;
        waitIdle();
        for (int r = 0; r < 9; r++) begin
            inTick = (r % 2 == 0);
            cycle();
        end
        compared += 2;
        if (outTick !== 1'b1) begin mismatched++; $display("FAIL rmid_pre_out: got %b want 1", outTick); end
        if (pending !== 4'd3) begin mismatched++; $display("FAIL rmid_pre_pending: got %0d want 3", pending); end
        resetN = 1'b0;
        inTick = 1'b1;
        cycle();
        compared += 3;
        if (outTick !== 1'b0) begin mismatched++; $display("FAIL rmid_out: got %b want 0", outTick); end
        if (pending !== 4'd0) begin mismatched++; $display("FAIL rmid_pending: got %0d want 0", pending); end
        if (busy !== 1'b0)    begin mismatched++; $display("FAIL rmid_busy: got %b want 0", busy); end
        resetN = 1'b1;
        for (int r = 0; r < 20; r++) begin
            cycle();
            if (outTick === 1'b1) highCycles++;
            if (outTick === 1'b1 && !prevOut) rises++;
            prevOut = outTick;
        end
        compared += 2;
        if (rises != 1)       begin mismatched++; $display("FAIL rmid_pulses: got %0d want 1", rises); end
        if (highCycles != PW) begin mismatched++; $display("FAIL rmid_width: got %0d want %0d", highCycles, PW); end
        inTick = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            inTick        = ($urandom_range(0, 2) != 0);
            clearOverflow = ($urandom_range(0, 15) == 0);
            resetN        = ($urandom_range(0, 199) != 0);
            cycle();
        end
        resetN = 1'b1;
        waitIdle();
    endtask

`ifdef SRT_TICK_PACER_STATS_EN
    task automatic test_stats();
        resetN = 1'b0;
        cycle();
        resetN = 1'b1;
        for (int p = 0; p < 5; p++) begin
            inTick = 1'b1;
            cycle();
            inTick = 1'b0;
            for (int k = 0; k < 8; k++) cycle();
        end
        compared++;
        if (emitCount !== 16'd5) begin mismatched++; $display("FAIL stats_five: got %0d want 5", emitCount); end
        force dut.emitCount = 16'hFFFE;
        mEmit = 16'hFFFE;
        #1;
        release dut.emitCount;
        inTick = 1'b1;
        cycle();
        inTick = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        compared++;
        if (emitCount !== 16'hFFFF) begin mismatched++; $display("FAIL stats_ffff: got %h want ffff", emitCount); end
        inTick = 1'b1;
        cycle();
        inTick = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        compared++;
        if (emitCount !== 16'h0000) begin mismatched++; $display("FAIL stats_wrap: got %h want 0000", emitCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef SRT_TICK_PACER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tick_pacer.md
TICK_PACER -- requirements
Module: tick_pacer

Interface
REQ-001 The block SHALL have parameter PULSE_WIDTH, default 2, meaning outTick high time in cycles (legal range 1..15).
REQ-002 The block SHALL have parameter MIN_GAP, default 4, meaning minimum outTick low time in cycles between pulses (legal range 1..15).
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 4, meaning width of the pending-tick counter.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clock  input  1  sole clock; all state updates on posedge.
- resetN  input  1  synchronous active-low reset.
- inTick  input  1  bursty tick request; each rising edge is one request.
- clearOverflow  input  1  clears the sticky overflow flag.
- outTick  output  1  paced tick, registered.
- pending  output  COUNT_WIDTH  queued, not-yet-emitted requests.
- busy  output  1  high when state is not IDLE or pending is nonzero.
- overflow  output  1  sticky; a request was dropped.

Function
REQ-005 The block SHALL detect a request as inTick high with the registered previous inTick low; a level held high SHALL count once.
REQ-006 A detected request SHALL increment pending on the next clock edge.
REQ-007 pending SHALL saturate at 2^COUNT_WIDTH-1; a request arriving at saturation SHALL be dropped and SHALL set overflow on the next edge.
REQ-008 The block SHALL have states IDLE, HIGH and GAP, held in registers.
- IDLE with pending!=0: go to HIGH and decrement pending.
- HIGH: stay PULSE_WIDTH cycles, then go to GAP.
- GAP: stay MIN_GAP cycles, then go to HIGH (decrementing pending) if pending!=0, else go to IDLE.
REQ-009 outTick SHALL be high exactly while in HIGH, giving pulses of exactly PULSE_WIDTH cycles separated by at least MIN_GAP low cycles.
REQ-010 Latency SHALL be fixed: inTick rises at cycle N with the block idle -> pending=1 at N+1 -> outTick high at N+2.
REQ-011 An increment and a decrement in the same cycle SHALL leave pending unchanged, and the arriving request SHALL NOT be dropped even when pending is saturated.
REQ-012 A single phase counter of 4 bits SHALL time both HIGH and GAP, reloaded on every state entry.
REQ-013 clearOverflow asserted in the same cycle as a new drop SHALL leave overflow set (set wins).

Reset
REQ-014 With resetN low at a posedge, the block SHALL reset: state=IDLE, pending=0, outTick=0, overflow=0, phase counter=0, and previous-inTick=0.
REQ-015 Reset asserted mid-pulse SHALL drop outTick on the following edge and discard all pending requests.
REQ-016 If inTick is high as reset releases, the block SHALL count it as one request.

Configuration
REQ-017 With macro SRT_TICK_PACER_STATS_EN defined, the block SHALL add output emitCount (16 bits), which increments on each entry to HIGH, wraps 0xFFFF->0, and resets to 0.
REQ-018 With SRT_TICK_PACER_STATS_EN undefined, emitCount and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-019 Package tick_pacer_pkg SHALL hold the state enum (IDLE/HIGH/GAP), the default PULSE_WIDTH/MIN_GAP/COUNT_WIDTH constants and the phase counter width.
REQ-020 Rising-edge detection SHALL live in sub-module tick_edge_detect (clock, resetN, in, rise), which is reused by the pacer.

Verification
REQ-021 The bench SHALL cover the following directed scenarios.
- Single pulse: inTick pulse at cycle 10 (defaults) -> outTick high in cycles 12-13, low after, pending 1 then 0.
- Burst: 3 edges on cycles 10,12,14 -> outTick high at 12-13, 18-19, 24-25; busy low from cycle 30.
- Saturation: 17 edges with COUNT_WIDTH=4 and outTick blocked in GAP -> pending=15, overflow=1; clearOverflow -> overflow=0 next cycle.
- Simultaneous: edge at the cycle GAP exits with pending=15 -> pending stays 15, overflow stays 0.
- Reset mid-HIGH with pending=3: resetN low one cycle -> outTick=0, pending=0, state IDLE next edge; inTick held high through release -> one pulse only.
- With STATS_EN: 5 emitted pulses -> emitCount=5; preload near wrap -> 0xFFFF then 0x0000.
